multicycle_alu: RTL

//  Multicycle ALU. Sits directly downstream of alu_decoder: consumes its 4-bit ALUControl plus SrcA/SrcB operands.

---
 rtl/multicycle_alu.sv | 133 +++++++++++++
 1 files changed

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - multicycle ALU with 1-bit-per-cycle iterative shifter
// Single-cycle arithmetic/logic/compare ops; shifts step one bit per clock behind a start/busy/done handshake.
module multicycle_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] cnt;
  logic [3:0]         shift_op;

  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;
  logic               is_illegal;
  logic               accept;
  logic [WIDTH-1:0]   comb_result;
  logic [WIDTH-1:0]   acc_next;

  always_comb begin
    shamt      = SrcB[SHAMT_W-1:0];
    is_shift   = (ALUControl == OP_SLL) || (ALUControl == OP_SRL) || (ALUControl == OP_SRA);
    is_illegal = (ALUControl > OP_SRA);
    accept     = start && !busy;
  end

  // Shifts reaching this path have shamt==0, so their result is SrcA unchanged.
  always_comb begin
    comb_result = '0;
    case (ALUControl)
      OP_ADD:  comb_result = SrcA + SrcB;
      OP_SUB:  comb_result = SrcA - SrcB;
      OP_AND:  comb_result = SrcA & SrcB;
      OP_OR:   comb_result = SrcA | SrcB;
      OP_XOR:  comb_result = SrcA ^ SrcB;
      OP_SLT:  comb_result = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SLTU: comb_result = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      OP_SLL, OP_SRL, OP_SRA: comb_result = SrcA;
      default: comb_result = '0;
    endcase
  end

  // SRA keeps acc's MSB fixed, so it always equals the original SrcA sign bit.
  always_comb begin
    acc_next = {acc[WIDTH-2:0], 1'b0};
    case (shift_op)
      OP_SRL:  acc_next = {1'b0, acc[WIDTH-1:1]};
      OP_SRA:  acc_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
      default: acc_next = {acc[WIDTH-2:0], 1'b0};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      shift_op  <= OP_ADD;
      ALUResult <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          acc <= acc_next;
          cnt <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) begin
            ALUResult <= acc_next;
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: begin
          done    <= 1'b0;
          illegal <= 1'b0;
          state   <= IDLE;
          if (accept) begin
            if (is_illegal) begin
              ALUResult <= '0;
              illegal   <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else if (is_shift && (shamt != '0)) begin
              acc      <= SrcA;
              cnt      <= shamt;
              shift_op <= ALUControl;
              busy     <= 1'b1;
              state    <= SHIFT;
            end else begin
              ALUResult <= comb_result;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
      endcase
    end
  end

  assign Zero = (ALUResult == '0);

endmodule
